// File: rtl/somador_subtrator_serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// Holds the FSM state encodings and the default operand width.
package somador_subtrator_serial_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/somador_completo_bit.sv
// One-bit full-adder slice with conditional inversion of b.
// With inv=1 and the carry seeded to 1, a chain of these slices computes a - b.
module somador_completo_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic inv,
    output logic s,
    output logic cout
);

    logic bEff;

    assign bEff = b ^ inv;
    assign s    = a ^ bEff ^ cin;
    assign cout = (a & bEff) | (a & cin) | (bEff & cin);

endmodule

// File: rtl/somador_subtrator_serial.sv
// Bit-serial adder/subtractor: processes one bit per clock, LSB first.
// Produces the result and the carry, overflow and zero flags, with a start/busy/done handshake.
module somador_subtrator_serial
    import somador_subtrator_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             Cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shA_q, shA_d;
    logic [WIDTH-1:0] shB_q, shB_d;
    logic [WIDTH-1:0] shR_q, shR_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             carry_q, carry_d;
    logic             cMsb_q, cMsb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic faSum;
    logic faCarry;

    somador_completo_bit u_fa (
        .a    (shA_q[0]),
        .b    (shB_q[0]),
        .cin  (carry_q),
        .inv  (op_q),
        .s    (faSum),
        .cout (faCarry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shA_q   <= '0;
            shB_q   <= '0;
            shR_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            cMsb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shA_q   <= shA_d;
            shB_q   <= shB_d;
            shR_q   <= shR_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cMsb_q  <= cMsb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // The partial sum accumulates in shR; R and the flags only load in DONE,
    // so they stay at zero for the whole SHIFT phase.
    always_comb begin
        state_d = state_q;
        shA_d   = shA_q;
        shB_d   = shB_q;
        shR_d   = shR_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        cMsb_d  = cMsb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        r_d     = r_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shA_d   = A;
                    shB_d   = B;
                    shR_d   = '0;
                    op_d    = sub;
                    carry_d = sub;
                    cnt_d   = '0;
                    cMsb_d  = 1'b0;
                    r_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shR_d   = {faSum, shR_q[WIDTH-1:1]};
                shA_d   = {1'b0, shA_q[WIDTH-1:1]};
                shB_d   = {1'b0, shB_q[WIDTH-1:1]};
                carry_d = faCarry;
                cnt_d   = cnt_q + CW'(1);
                // The carry entering the MSB slice is needed for signed overflow.
                if (cnt_q == LAST_BIT) begin
                    cMsb_d  = carry_q;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                r_d     = shR_q;
                cout_d  = carry_q;
                ovf_d   = cMsb_q ^ carry_q;
                zero_d  = (shR_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign R        = r_q;
    assign Cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Directed self-checking bench for the bit-serial adder/subtractor (WIDTH=8).
module tb_somador_subtrator_serial;
    import somador_subtrator_serial_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] R;
    logic       Cout;
    logic       overflow;
    logic       zero;

    int checkCount = 0;
    int errorCount = 0;

    somador_subtrator_serial #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .R        (R),
        .Cout     (Cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one request for a single clock; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        A     = a;
        B     = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
        end
    endtask

    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] expR, input logic expC, input logic expV, input logic expZ);
        int edges;
        applyStimulus(a, b, s);
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " R hidden"}, 32'(R), 32'h00);
        waitDone(edges);
        checkOutput({tag, " latency"}, 32'(edges), 32'd9);
        checkOutput({tag, " R"}, 32'(R), 32'(expR));
        checkOutput({tag, " Cout"}, 32'(Cout), 32'(expC));
        checkOutput({tag, " ovf"}, 32'(overflow), 32'(expV));
        checkOutput({tag, " zero"}, 32'(zero), 32'(expZ));
        checkOutput({tag, " busy@done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
        checkOutput({tag, " R held"}, 32'(R), 32'(expR));
    endtask

    initial begin
        int edges;
        int donePulses;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst R", 32'(R), 32'h00);
        checkOutput("rst flags", {29'd0, Cout, overflow, zero}, 32'd0);
        rst = 1'b0;

        runOp("add 5+3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        runOp("sub 5-7", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        runOp("add 7F+1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        runOp("sub 80-1", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        runOp("add FF+1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle hold R", 32'(R), 32'h00);
        checkOutput("idle hold zero", 32'(zero), 32'd1);

        runOp("sub B=0", 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);

        // Keep start high through SHIFT and DONE with different operands.
        applyStimulus(8'h21, 8'h12, 1'b1);
        A          = 8'hFF;
        B          = 8'hFF;
        sub        = 1'b0;
        start      = 1'b1;
        edges      = 0;
        donePulses = 0;
        while (edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                donePulses++;
                start = 1'b0;
                break;
            end
        end
        checkOutput("ignore latency", 32'(edges), 32'd9);
        checkOutput("ignore R", 32'(R), 32'h0F);
        checkOutput("ignore Cout", 32'(Cout), 32'd1);
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) donePulses++;
        end
        checkOutput("ignore one done", 32'(donePulses), 32'd1);
        checkOutput("ignore no restart", 32'(busy), 32'd0);

        // Abort mid-operation.
        applyStimulus(8'h33, 8'h44, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort R", 32'(R), 32'h00);
        checkOutput("abort flags", {29'd0, Cout, overflow, zero}, 32'd0);
        checkOutput("abort state", 32'(dut.state_q), 32'(IDLE));
        donePulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) donePulses++;
        end
        checkOutput("abort no done", 32'(donePulses), 32'd0);

        runOp("post-abort 10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
